pixel_sequencer: RTL and testbench

- Sequences one frame of iteration results from N_ENG parallel fractal engines through the single shared combinational colour-map stage.
- Emits a raster-ordered RGB pixel stream with valid/ready handshake and frame/line markers.
- Engine k owns pixel columns x where x mod N_ENG == k, so grants rotate in strict order (no skipping) to preserve raster order.
- Latches max_iter/colour at frame start and drives them to the colour map for the whole frame.

---
 rtl/pixel_sequencer.sv | 169 ++++++++++++++++
 tb/tb_pixel_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_sequencer.sv
// Pixel sequencer: rotates grants over N_ENG fractal engines in raster order,
// drives the shared colour map and registers one RGB pixel per accept.
module pixel_sequencer #(
    parameter int N_ENG          = 4,
    parameter int MAX_ITER_WIDTH = 16,
    parameter int X_SIZE         = 640,
    parameter int Y_SIZE         = 480
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic [MAX_ITER_WIDTH-1:0]       max_iter_i,
    input  logic [1:0]                      colour_i,
    output logic                            busy_o,
    output logic                            done_o,
    input  logic [N_ENG-1:0]                eng_valid_i,
    input  logic [N_ENG*MAX_ITER_WIDTH-1:0] eng_iter_i,
    output logic [N_ENG-1:0]                eng_ready_o,
    output logic [MAX_ITER_WIDTH-1:0]       cm_max_iter_o,
    output logic [MAX_ITER_WIDTH-1:0]       cm_iter_o,
    output logic [1:0]                      cm_colour_o,
    input  logic [7:0]                      cm_r_i,
    input  logic [7:0]                      cm_g_i,
    input  logic [7:0]                      cm_b_i,
    output logic [23:0]                     out_data_o,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic                            out_user_o,
    output logic                            out_last_o
);

    localparam int PW = (N_ENG > 1) ? $clog2(N_ENG) : 1;
    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [PW-1:0]             r_ptr;
    logic [XW-1:0]             r_x;
    logic [YW-1:0]             r_y;
    logic [MAX_ITER_WIDTH-1:0] r_max_iter;
    logic [1:0]                r_colour;
    logic                      r_done;
    logic [23:0]               r_out_data;
    logic                      r_out_valid;
    logic                      r_out_user;
    logic                      r_out_last;

    logic                      w_drain;
    logic                      w_grant;
    logic                      w_flush_done;
    logic                      w_accept;
    logic                      w_x_end;
    logic                      w_y_end;
    logic [MAX_ITER_WIDTH-1:0] w_iter_sel;
    logic [MAX_ITER_WIDTH-1:0] w_iter_clamp;

    // Output register can take a new pixel if empty or emptying this cycle
    assign w_drain    = !r_out_valid || out_ready_i;
    assign w_x_end    = (r_x == X_LAST);
    assign w_y_end    = (r_y == Y_LAST);
    assign w_iter_sel = eng_iter_i[int'(r_ptr)*MAX_ITER_WIDTH +: MAX_ITER_WIDTH];
    assign w_accept   = w_grant && eng_valid_i[r_ptr];

    // Counts past max_iter are treated as inside the set
    assign w_iter_clamp = (w_iter_sel > r_max_iter) ? r_max_iter : w_iter_sel;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept && w_x_end && w_y_end) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_drain) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_grant      = 1'b0;
        w_flush_done = 1'b0;
        unique case (r_state)
            S_RUN:   w_grant      = w_drain;
            S_FLUSH: w_flush_done = w_drain;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_max_iter  <= '0;
            r_colour    <= '0;
            r_done      <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_user  <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_done <= w_flush_done;
            if (r_state == S_IDLE && start_i) begin
                r_max_iter <= max_iter_i;
                r_colour   <= colour_i;
                r_ptr      <= '0;
                r_x        <= '0;
                r_y        <= '0;
            end
            if (w_accept) begin
                r_ptr <= r_ptr + PW'(1);
                if (w_x_end) begin
                    r_x <= '0;
                    r_y <= w_y_end ? '0 : r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
            if (w_accept) begin
                r_out_data  <= {cm_r_i, cm_g_i, cm_b_i};
                r_out_valid <= 1'b1;
                r_out_user  <= (r_x == '0) && (r_y == '0);
                r_out_last  <= w_x_end;
            end else if (out_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign busy_o        = (r_state != S_IDLE);
    assign done_o        = r_done;
    assign eng_ready_o   = w_grant ? (N_ENG'(1) << r_ptr) : '0;
    assign cm_max_iter_o = r_max_iter;
    assign cm_colour_o   = r_colour;
    assign cm_iter_o     = (r_state == S_RUN) ? w_iter_clamp : '0;
    assign out_data_o    = r_out_data;
    assign out_valid_o   = r_out_valid;
    assign out_user_o    = r_out_user;
    assign out_last_o    = r_out_last;

endmodule

// File: tb/tb_pixel_sequencer.sv
// Bench for pixel_sequencer on an 8x2 frame with four engines and a
// behavioural colour map; a scoreboard follows every accepted pixel.
module tb_pixel_sequencer;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int XS   = 8;
    localparam int YS   = 2;
    localparam int NPIX = XS * YS;

    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   max_iter;
    logic [1:0]     colour;
    logic           busy;
    logic           done;
    logic [N-1:0]   eng_valid;
    logic [N*W-1:0] eng_iter;
    logic [N-1:0]   eng_ready;
    logic [W-1:0]   cm_max;
    logic [W-1:0]   cm_iter;
    logic [1:0]     cm_colour;
    logic [7:0]     cm_r;
    logic [7:0]     cm_g;
    logic [7:0]     cm_b;
    logic [23:0]    out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_user;
    logic           out_last;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic [W-1:0] iter_tab [NPIX];
    int eng_cnt [N];
    int exp_ptr;
    exp_t q[$];
    logic [W-1:0] tb_max;
    logic [1:0] tb_col;
    int hs_cnt, first_hs, last_hs, done_cnt, done_cyc;
    int stall_eng, stall_left, hold_left;
    logic [23:0] got [NPIX];
    logic acc_prev;

    always #5 clk = ~clk;

    pixel_sequencer #(
        .N_ENG(N), .MAX_ITER_WIDTH(W), .X_SIZE(XS), .Y_SIZE(YS)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .max_iter_i(max_iter), .colour_i(colour),
        .busy_o(busy), .done_o(done),
        .eng_valid_i(eng_valid), .eng_iter_i(eng_iter),
        .eng_ready_o(eng_ready),
        .cm_max_iter_o(cm_max), .cm_iter_o(cm_iter),
        .cm_colour_o(cm_colour),
        .cm_r_i(cm_r), .cm_g_i(cm_g), .cm_b_i(cm_b),
        .out_data_o(out_data), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_user_o(out_user),
        .out_last_o(out_last)
    );

    // Behavioural colour map: black at max_iter, otherwise a simple mix
    function automatic logic [23:0] cmap(input logic [W-1:0] it,
                                         input logic [W-1:0] mx,
                                         input logic [1:0] col);
        if (it == mx) return 24'h0;
        return {it[7:0], it[15:8] ^ {col, 6'd0},
                8'h5A ^ it[7:0] ^ {6'd0, col}};
    endfunction

    assign {cm_r, cm_g, cm_b} = cmap(cm_iter, cm_max, cm_colour);

    always @(negedge clk) begin
        int p;
        logic [W-1:0] it;
        exp_t e;
        cyc++;
        if (rst) begin
            acc_prev = 1'b0;
        end else begin
            if (acc_prev) begin
                n_cmp++;
                if (out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL latency: out_valid=%b want 1", out_valid);
                end
            end
            acc_prev = 1'b0;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_pixel: data=%h want none", out_data);
                end else begin
                    e = q.pop_front();
                    if ({out_data, out_user, out_last} !== {e.d, e.u, e.l}) begin
                        n_err++;
                        $display("FAIL pixel%0d: got %h/%b/%b want %h/%b/%b",
                                 hs_cnt, out_data, out_user, out_last,
                                 e.d, e.u, e.l);
                    end
                end
                if (hs_cnt < NPIX) got[hs_cnt] = out_data;
                if (hs_cnt == 0) first_hs = cyc;
                last_hs = cyc;
                hs_cnt++;
            end
            n_cmp++;
            if ($countones(eng_ready) > 1) begin
                n_err++;
                $display("FAIL onehot: eng_ready=%b want <=1 bit", eng_ready);
            end
            for (int k = 0; k < N; k++) begin
                if (eng_ready[k] && eng_valid[k]) begin
                    n_cmp++;
                    if (k != exp_ptr) begin
                        n_err++;
                        $display("FAIL grant_order: got %0d want %0d", k, exp_ptr);
                    end
                    p = eng_cnt[k] * N + k;
                    it = (iter_tab[p] > tb_max) ? tb_max : iter_tab[p];
                    n_cmp++;
                    if (cm_iter !== it) begin
                        n_err++;
                        $display("FAIL cm_iter p%0d: got %0d want %0d", p, cm_iter, it);
                    end
                    e.d = cmap(it, tb_max, tb_col);
                    e.u = (p == 0);
                    e.l = ((p % XS) == XS - 1);
                    q.push_back(e);
                    eng_cnt[k]++;
                    exp_ptr = (exp_ptr + 1) % N;
                    acc_prev = 1'b1;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            eng_valid[k] = !(k == stall_eng && stall_left > 0)
                           && (eng_cnt[k] < NPIX / N);
            eng_iter[k*W +: W] = iter_tab[(eng_cnt[k] * N + k) % NPIX];
        end
        out_ready = (hold_left == 0);
        if (stall_left > 0) stall_left--;
        if (hold_left > 0) hold_left--;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
        #1;
    endtask

    task automatic new_frame(input logic [W-1:0] mx, input logic [1:0] col);
        q.delete();
        for (int k = 0; k < N; k++) eng_cnt[k] = 0;
        exp_ptr = 0;
        hs_cnt = 0;
        done_cnt = 0;
        first_hs = 0;
        last_hs = 0;
        done_cyc = 0;
        tb_max = mx;
        tb_col = col;
        stall_left = 0;
        hold_left = 0;
        start = 1'b0;
        for (int p = 0; p < NPIX; p++) iter_tab[p] = W'(p * 37 + 3);
    endtask

    task automatic start_frame();
        max_iter = tb_max;
        colour = tb_col;
        start = 1'b1;
        tick();
        start = 1'b0;
        max_iter = 16'hFFFF;
        colour = ~tb_col;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        new_frame(16'd99, 2'd3);
        max_iter = 16'h1234;
        colour = 2'd2;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if ({busy, done, eng_ready, out_valid, out_user, out_last,
                 out_data, cm_max, cm_iter, cm_colour} !== '0) begin
                n_err++;
                $display("FAIL reset_idle: busy=%b done=%b rdy=%b v=%b d=%h cm=%h/%h/%h want 0",
                         busy, done, eng_ready, out_valid, out_data,
                         cm_max, cm_iter, cm_colour);
            end
        end
        n_cmp++;
        if (done_cnt != 0) begin
            n_err++;
            $display("FAIL reset_done: got %0d pulses want 0", done_cnt);
        end
    endtask

    task automatic test_small_frame();
        new_frame(16'd256, 2'd1);
        start_frame();
        tick();
        n_cmp++;
        if ({busy, cm_max, cm_colour} !== {1'b1, 16'd256, 2'd1}) begin
            n_err++;
            $display("FAIL cfg_latch: busy=%b max=%0d col=%0d want 1/256/1",
                     busy, cm_max, cm_colour);
        end
        for (int i = 0; i < 200 && done_cnt == 0; i++) tick();
        repeat (3) tick();
        n_cmp++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL small_done: got %0d pulses want 1", done_cnt);
        end
        n_cmp++;
        if (hs_cnt != NPIX || last_hs - first_hs != NPIX - 1) begin
            n_err++;
            $display("FAIL small_rate: got %0d px over %0d cyc want %0d/%0d",
                     hs_cnt, last_hs - first_hs, NPIX, NPIX - 1);
        end
        n_cmp++;
        if (done_cyc != last_hs + 1) begin
            n_err++;
            $display("FAIL done_timing: got cyc %0d want %0d", done_cyc, last_hs + 1);
        end
        n_cmp++;
        if (busy !== 1'b0 || q.size() != 0) begin
            n_err++;
            $display("FAIL small_end: busy=%b pending=%0d want 0/0", busy, q.size());
        end
    endtask

    task automatic test_iter_map();
        new_frame(16'd512, 2'd2);
        iter_tab[2] = 16'd600;
        iter_tab[0] = 16'd0;
        start_frame();
        for (int i = 0; i < 200 && done_cnt == 0; i++) tick();
        tick();
        n_cmp++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL map_done: got %0d want 1", done_cnt);
        end
        n_cmp++;
        if (got[2] !== 24'h000000) begin
            n_err++;
            $display("FAIL map_clamp: got %h want 000000", got[2]);
        end
        n_cmp++;
        if (got[0] !== 24'h008058) begin
            n_err++;
            $display("FAIL map_zero: got %h want 008058", got[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [25:0] held;
        new_frame(16'd1000, 2'd0);
        start_frame();
        for (int i = 0; i < 50 && hs_cnt < 3; i++) tick();
        hold_left = 5;
        tick();
        held = {out_data, out_user, out_last};
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || eng_ready !== '0
                || {out_data, out_user, out_last} !== held) begin
                n_err++;
                $display("FAIL bp_hold%0d: v=%b rdy=%b d=%h want 1/0/%h",
                         i, out_valid, eng_ready, out_data, held[25:2]);
            end
            tick();
        end
        for (int i = 0; i < 200 && done_cnt == 0; i++) tick();
        tick();
        n_cmp++;
        if (hs_cnt != NPIX || q.size() != 0 || done_cnt != 1) begin
            n_err++;
            $display("FAIL bp_count: px=%0d pend=%0d done=%0d want %0d/0/1",
                     hs_cnt, q.size(), done_cnt, NPIX);
        end
    endtask

    task automatic test_stall();
        new_frame(16'd300, 2'd3);
        stall_eng = 1;
        stall_left = 1000;
        start_frame();
        for (int i = 0; i < 50 && exp_ptr != 1; i++) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (eng_ready !== 4'b0010 || eng_valid[3:2] !== 2'b11) begin
                n_err++;
                $display("FAIL stall%0d: rdy=%b vld=%b want 0010/11xx",
                         i, eng_ready, eng_valid);
            end
        end
        stall_left = 0;
        for (int i = 0; i < 200 && done_cnt == 0; i++) tick();
        tick();
        n_cmp++;
        if (hs_cnt != NPIX || done_cnt != 1) begin
            n_err++;
            $display("FAIL stall_end: px=%0d done=%0d want %0d/1",
                     hs_cnt, done_cnt, NPIX);
        end
    endtask

    task automatic test_start_and_reset();
        new_frame(16'd700, 2'd2);
        start_frame();
        for (int i = 0; i < 50 && hs_cnt < 2; i++) tick();
        max_iter = 16'd5;
        colour = 2'd1;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        n_cmp++;
        if ({busy, cm_max, cm_colour} !== {1'b1, 16'd700, 2'd2}) begin
            n_err++;
            $display("FAIL start_ignored: busy=%b max=%0d col=%0d want 1/700/2",
                     busy, cm_max, cm_colour);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({busy, done, eng_ready, out_valid, out_user, out_last,
             out_data, cm_max, cm_iter, cm_colour} !== '0) begin
            n_err++;
            $display("FAIL mid_reset: busy=%b v=%b d=%h cm=%h want 0",
                     busy, out_valid, out_data, cm_max);
        end
        rst = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_done: done=%0d busy=%b want 0/0", done_cnt, busy);
        end
        new_frame(16'd100, 2'd1);
        start_frame();
        for (int i = 0; i < 200 && done_cnt == 0; i++) tick();
        tick();
        n_cmp++;
        if (hs_cnt != NPIX || done_cnt != 1 || q.size() != 0) begin
            n_err++;
            $display("FAIL clean_frame: px=%0d done=%0d pend=%0d want %0d/1/0",
                     hs_cnt, done_cnt, q.size(), NPIX);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        max_iter = '0;
        colour = '0;
        eng_valid = '0;
        eng_iter = '0;
        out_ready = 1'b1;
        stall_eng = 0;
        acc_prev = 1'b0;
        test_reset();
        test_small_frame();
        test_iter_map();
        test_backpressure();
        test_stall();
        test_start_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
